// File: rtl/icap_ser_pkg.sv
// Shared types and helpers for the ICAP word serializer: FSM states,
// ICAP/length widths and the per-byte bit reversal used by Xilinx ICAP.
package icap_ser_pkg;

    localparam int ICAP_WIDTH = 32;
    localparam int LEN_W      = 24;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ICAP expects the bit order inside every byte mirrored.
    function automatic logic [ICAP_WIDTH-1:0] bitrev_bytes(input logic [ICAP_WIDTH-1:0] w);
        logic [ICAP_WIDTH-1:0] r;
        for (int b = 0; b < ICAP_WIDTH/8; b++) begin
            for (int i = 0; i < 8; i++) begin
                r[8*b + i] = w[8*b + 7 - i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/icap_word_serializer.sv
// Pops wide FIFO beats and streams them MSB-word-first onto the 32-bit ICAP
// port, keeping csib low back-to-back across beats while data is available.
module icap_word_serializer
    import icap_ser_pkg::*;
#(
    parameter int DATA_SIZE = 256,
    parameter bit BIT_SWAP  = 1'b1
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic [DATA_SIZE-1:0]  fifo_rdata,
    input  logic                  fifo_rempty,
    output logic                  fifo_rinc,
    output logic [ICAP_WIDTH-1:0] icap_i,
    output logic                  icap_csib,
    output logic                  icap_rdwrb,
    output logic                  busy,
    output logic                  done
);

    localparam int WPB   = DATA_SIZE / ICAP_WIDTH;
    localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LEN_W-1:0]      r_remaining;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_SIZE-1:0]  r_shift;
    logic [ICAP_WIDTH-1:0] r_icap_i;
    logic                  r_csib;
    logic                  r_rdwrb;

    logic                  w_pop;
    logic                  w_last;
    logic                  w_beat_end;
    logic [ICAP_WIDTH-1:0] w_fmt_in;
    logic [ICAP_WIDTH-1:0] w_fmt_sh;

    assign w_last     = (r_remaining == LEN_W'(1));
    assign w_beat_end = (r_idx == IDX_W'(WPB - 1));
    assign w_fmt_in   = BIT_SWAP ? bitrev_bytes(fifo_rdata[DATA_SIZE-1 -: ICAP_WIDTH])
                                 : fifo_rdata[DATA_SIZE-1 -: ICAP_WIDTH];
    assign w_fmt_sh   = BIT_SWAP ? bitrev_bytes(r_shift[DATA_SIZE-1 -: ICAP_WIDTH])
                                 : r_shift[DATA_SIZE-1 -: ICAP_WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (cfg_len == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (!fifo_rempty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // The final word wins over a beat boundary so a trailing beat is never popped.
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end else if (w_beat_end) begin
                    if (!fifo_rempty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_state     <= S_IDLE;
            r_csib      <= 1'b1;
            r_rdwrb     <= 1'b1;
            r_icap_i    <= '0;
            r_remaining <= '0;
            r_idx       <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_remaining <= cfg_len;
                        r_rdwrb     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        r_csib  <= 1'b1;
                        r_rdwrb <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        r_csib  <= 1'b1;
                        r_rdwrb <= 1'b1;
                    end else begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (w_last) begin
                            r_csib <= 1'b1;
                        end else if (!w_beat_end) begin
                            r_icap_i <= w_fmt_sh;
                            r_idx    <= r_idx + IDX_W'(1);
                        end else if (fifo_rempty) begin
                            r_csib <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_rdwrb <= 1'b1;
                end
                default: ;
            endcase
            if (w_pop) begin
                r_icap_i <= w_fmt_in;
                r_idx    <= '0;
                r_csib   <= 1'b0;
            end
        end
    end

    // Beat payload needs no reset; it is always reloaded by a pop before use.
    always_ff @(posedge rclk) begin
        if (w_pop && !rrst) begin
            r_shift <= fifo_rdata << ICAP_WIDTH;
        end else if (r_state == S_SHIFT && !w_beat_end) begin
            r_shift <= r_shift << ICAP_WIDTH;
        end
    end

    assign fifo_rinc  = w_pop & ~rrst;
    assign icap_i     = r_icap_i;
    assign icap_csib  = r_csib;
    assign icap_rdwrb = r_rdwrb;
    assign busy       = (r_state != S_IDLE) & ~rrst;
    assign done       = (r_state == S_DONE) & ~abort & ~rrst;

endmodule

// File: tb/tb_icap_word_serializer.sv
// Directed bench for icap_word_serializer: a swapping and a non-swapping
// instance share one FIFO model and stimulus.
module tb_icap_word_serializer;

    localparam int DS = 256;

    logic          clk = 1'b0;
    logic          rrst;
    logic          start;
    logic          abort;
    logic [23:0]   cfg_len;
    logic [DS-1:0] mem [0:63];
    int            wr_cnt = 0;
    int            rd_ptr = 0;
    logic          fifo_rempty;
    logic [DS-1:0] fifo_rdata;

    logic        rinc_s, csib_s, rdwrb_s, busy_s, done_s;
    logic [31:0] icap_s;
    logic        rinc_r, csib_r, rdwrb_r, busy_r, done_r;
    logic [31:0] icap_r;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int viol     = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [31:0] got_s [$];
    logic [31:0] got_r [$];
    int          got_c [$];

    int base_w, base_d, base_p;

    always #5 clk = ~clk;

    assign fifo_rempty = (rd_ptr >= wr_cnt);
    assign fifo_rdata  = mem[rd_ptr % 64];

    icap_word_serializer #(.DATA_SIZE(DS), .BIT_SWAP(1'b1)) dut_s (
        .rclk(clk), .rrst(rrst), .start(start), .abort(abort), .cfg_len(cfg_len),
        .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_rinc(rinc_s),
        .icap_i(icap_s), .icap_csib(csib_s), .icap_rdwrb(rdwrb_s),
        .busy(busy_s), .done(done_s)
    );

    icap_word_serializer #(.DATA_SIZE(DS), .BIT_SWAP(1'b0)) dut_r (
        .rclk(clk), .rrst(rrst), .start(start), .abort(abort), .cfg_len(cfg_len),
        .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_rinc(rinc_r),
        .icap_i(icap_r), .icap_csib(csib_r), .icap_rdwrb(rdwrb_r),
        .busy(busy_r), .done(done_r)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rrst && rinc_s) rd_ptr <= rd_ptr + 1;
        if ((rinc_s || rinc_r) && fifo_rempty) viol <= viol + 1;
    end

    always @(negedge clk) begin
        if (!csib_s) begin
            got_s.push_back(icap_s);
            got_c.push_back(cyc);
        end
        if (!csib_r) got_r.push_back(icap_r);
        if (done_s) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] rev8(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = w[(i / 8) * 8 + 7 - (i % 8)];
        return r;
    endfunction

    function automatic logic [31:0] beat_word(input int beat, input int k);
        logic [DS-1:0] b;
        b = mem[beat % 64];
        return b[DS-1-32*k -: 32];
    endfunction

    task automatic load_beat(input logic [7:0] tag);
        logic [DS-1:0] b;
        for (int k = 0; k < DS/32; k++) b[DS-1-32*k -: 32] = {tag, 8'(k), 8'hC3, 8'h3C};
        mem[wr_cnt % 64] = b;
        wr_cnt++;
    endtask

    task automatic snap();
        base_w = got_s.size();
        base_d = done_cnt;
        base_p = rd_ptr;
    endtask

    task automatic go(input logic [23:0] len);
        start   = 1'b1;
        cfg_len = len;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_words(input int n, input int limit);
        int t = 0;
        while ((got_s.size() - base_w) < n && t < limit) begin
            tick();
            t++;
        end
    endtask

    task automatic check_words(input string tag, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (got_s[base_w + i] !== rev8(beat_word(base_p + i / 8, i % 8))) bad++;
        end
        check(tag, 64'(bad), 64'd0);
    endtask

    initial begin
        rrst = 1'b1; start = 1'b0; abort = 1'b0; cfg_len = '0;
        load_beat(8'h10);
        mem[0][DS-1 -: 32] = 32'h01020304;
        load_beat(8'h11);
        tick(3);
        check("rst_csib",  64'(csib_s),  64'd1);
        check("rst_rdwrb", 64'(rdwrb_s), 64'd1);
        check("rst_icap",  64'(icap_s),  64'd0);
        check("rst_done",  64'(done_s),  64'd0);
        check("rst_busy",  64'(busy_s | busy_r), 64'd0);
        check("rst_rinc",  64'(rinc_s),  64'd0);
        check("rst_csib_r", 64'(csib_r & rdwrb_r & ~done_r), 64'd1);
        rrst = 1'b0;
        tick();

        // 16 words over two preloaded beats
        snap();
        go(24'd16);
        check("t1_busy",  64'(busy_s),  64'd1);
        check("t1_rdwrb", 64'(rdwrb_s), 64'd0);
        wait_words(16, 60);
        tick(3);
        check("t1_nwords", 64'(got_s.size() - base_w), 64'd16);
        check("t1_consec", 64'(got_c[base_w + 15] - got_c[base_w]), 64'd15);
        check("t1_pops",   64'(rd_ptr - base_p), 64'd2);
        check("t1_done",   64'(done_cnt - base_d), 64'd1);
        check("t1_done_lat", 64'(done_cyc - got_c[base_w + 15]), 64'd1);
        check("t1_swap0",  64'(got_s[base_w]), 64'h8040C020);
        check("t1_raw0",   64'(got_r[base_w]), 64'h01020304);
        check("t1_raw9",   64'(got_r[base_w + 9]), 64'h1101C33C);
        check_words("t1_words", 16);
        check("t1_idle",   64'({busy_s, rdwrb_s}), 64'b01);

        // cfg_len=10 with the FIFO running dry after the first beat
        load_beat(8'h20);
        snap();
        go(24'd10);
        wait_words(8, 40);
        tick(5);
        check("t3_gap_csib", 64'({csib_s, busy_s}), 64'b11);
        check("t3_gap_nw",   64'(got_s.size() - base_w), 64'd8);
        load_beat(8'h21);
        wait_words(10, 40);
        tick(3);
        check("t3_nwords", 64'(got_s.size() - base_w), 64'd10);
        check("t3_gap",    64'((got_c[base_w + 8] - got_c[base_w + 7] - 1) >= 5), 64'd1);
        check("t3_pops",   64'(rd_ptr - base_p), 64'd2);
        check("t3_done",   64'(done_cnt - base_d), 64'd1);
        check_words("t3_words", 10);

        // zero-length transfer
        load_beat(8'h30);
        snap();
        go(24'd0);
        check("t4_done_hi", 64'({done_s, csib_s}), 64'b11);
        tick();
        check("t4_done_lo", 64'({done_s, busy_s}), 64'b00);
        tick(3);
        check("t4_pops",   64'(rd_ptr - base_p), 64'd0);
        check("t4_nwords", 64'(got_s.size() - base_w), 64'd0);
        check("t4_done",   64'(done_cnt - base_d), 64'd1);

        // abort at the third word
        load_beat(8'h31);
        snap();
        go(24'd16);
        wait_words(3, 20);
        abort = 1'b1;
        tick();
        check("t5_csib", 64'(csib_s), 64'd1);
        check("t5_busy", 64'({busy_s, done_s}), 64'b00);
        abort = 1'b0;
        tick(10);
        check("t5_nwords", 64'(got_s.size() - base_w), 64'd3);
        check("t5_pops",   64'(rd_ptr - base_p), 64'd1);
        check("t5_done",   64'(done_cnt - base_d), 64'd0);
        wr_cnt = rd_ptr;

        // reset mid-beat, then an 8-word transfer
        load_beat(8'h40);
        load_beat(8'h41);
        snap();
        go(24'd16);
        wait_words(4, 20);
        rrst = 1'b1;
        tick();
        check("t6_rst_out", 64'({csib_s, rdwrb_s, done_s, busy_s, rinc_s}), 64'b11000);
        check("t6_rst_icap", 64'(icap_s), 64'd0);
        tick();
        rrst = 1'b0;
        tick();
        check("t6_pops", 64'(rd_ptr - base_p), 64'd1);
        wr_cnt = rd_ptr;
        load_beat(8'h50);
        snap();
        go(24'd8);
        wait_words(8, 30);
        tick(3);
        check("t6_nwords", 64'(got_s.size() - base_w), 64'd8);
        check("t6_consec", 64'(got_c[base_w + 7] - got_c[base_w]), 64'd7);
        check("t6_pops2",  64'(rd_ptr - base_p), 64'd1);
        check("t6_done",   64'(done_cnt - base_d), 64'd1);
        check_words("t6_words", 8);

        check("rinc_empty", 64'(viol), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
